block_stack: RTL and testbench

BLOCK_STACK -- requirements
Module: block_stack

---
 rtl/block_stack_pkg.sv | 32 +++
 rtl/block_stack_frames.sv | 39 +++
 rtl/block_stack.sv | 248 ++++++++++++++++++++++++
 tb/tb_block_stack.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_stack_pkg.sv
// Shared encodings for the block stack: opcodes, result codes and controller states.
package block_stack_pkg;

   typedef enum logic [3:0] {
      OP_NOP     = 4'd0,
      OP_PUSH    = 4'd1,
      OP_POP     = 4'd2,
      OP_REPLACE = 4'd3,
      OP_ENTER   = 4'd4,
      OP_LEAVE   = 4'd5,
      OP_GET     = 4'd6,
      OP_SET     = 4'd7
   } op_e;

   typedef enum logic [3:0] {
      STS_NONE            = 4'd0,
      STS_EMPTY           = 4'd1,
      STS_FULL            = 4'd2,
      STS_UNDERFLOW       = 4'd3,
      STS_OVERFLOW        = 4'd4,
      STS_BAD_OFFSET      = 4'd5,
      STS_FRAME_OVERFLOW  = 4'd6,
      STS_FRAME_UNDERFLOW = 4'd7,
      STS_UNKNOWN_OP      = 4'd8
   } status_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_COPY = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/block_stack_frames.sv
// Frame-base LIFO: saves the caller's frame bottom on ENTER, restores it on LEAVE.
module block_stack_frames #(
   parameter int FDEPTH = 4,
   parameter int AW     = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [AW-1:0]     i_data,
   output logic [AW-1:0]     o_top,
   output logic [FDEPTH:0]   o_depth
);
   localparam int FMAX = 2**FDEPTH;

   logic [AW-1:0]     r_mem [FMAX];
   logic [FDEPTH:0]   r_depth;
   logic [FDEPTH-1:0] w_top_addr;

   // wraps correctly when the LIFO is completely full
   assign w_top_addr = r_depth[FDEPTH-1:0] - FDEPTH'(1);
   assign o_top      = r_mem[w_top_addr];
   assign o_depth    = r_depth;

   always_ff @(posedge i_clk) begin
      if (i_push)
         r_mem[r_depth[FDEPTH-1:0]] <= i_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_depth <= '0;
      else if (i_push)
         r_depth <= r_depth + (FDEPTH+1)'(1);
      else if (i_pop)
         r_depth <= r_depth - (FDEPTH+1)'(1);
   end

endmodule

// File: rtl/block_stack.sv
// Operand stack with frame support and multi-lane top-of-stack view.
//   state  | meaning
//   S_IDLE | accepting ops, single-cycle completion
//   S_COPY | LEAVE moving kept entries down to the frame bottom, one per cycle
module block_stack
   import block_stack_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 7,
   parameter int FDEPTH = 4,
   parameter int OUTS   = 3
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_op_valid,
   output logic                  o_op_ready,
   input  logic [3:0]            i_op,
   input  logic [WIDTH-1:0]      i_data,
   input  logic [DEPTH:0]        i_count,
   input  logic [DEPTH:0]        i_offset,
   output logic [DEPTH:0]        o_index,
   output logic [DEPTH:0]        o_frame_base,
   output logic [FDEPTH:0]       o_frame_depth,
   output logic [OUTS*WIDTH-1:0] o_out,
   output logic [3:0]            o_status,
   output logic                  o_done
);
   localparam int MAX = 2**DEPTH;
   localparam int AW  = DEPTH + 1;
   localparam int PW  = DEPTH + 2;
   localparam logic [AW-1:0]     MAX_IDX = AW'(MAX);
   localparam logic [FDEPTH:0]   FMAX_D  = (FDEPTH+1)'(2**FDEPTH);

   logic [WIDTH-1:0]      r_mem [MAX];
   ctrl_state_e           r_state;
   logic [AW-1:0]         r_index, r_fb, r_src, r_dst, r_left, r_cnt;
   logic [OUTS*WIDTH-1:0] r_out;
   status_e               r_status;
   logic                  r_done, r_ready;

   logic                  w_fr_push, w_fr_pop;
   logic [AW-1:0]         w_fr_top;
   logic [FDEPTH:0]       w_fr_depth;

   logic                  w_accept, w_err, w_finish, w_go_copy, w_get, w_we;
   status_e               w_err_code, w_st_n;
   logic [AW-1:0]         w_idx_n, w_fb_n, w_src_n, w_dst_n, w_left_n, w_cnt_n, w_waddr, w_avail;
   logic [WIDTH-1:0]      w_wdata;
   logic [PW-1:0]         w_pos, w_lp;
   logic [OUTS*WIDTH-1:0] w_lanes;

   block_stack_frames #(.FDEPTH(FDEPTH), .AW(AW)) u_frames (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_fr_push),
      .i_pop   (w_fr_pop),
      .i_data  (r_fb),
      .o_top   (w_fr_top),
      .o_depth (w_fr_depth)
   );

   assign w_accept = i_op_valid && r_ready;
   assign w_pos    = {1'b0, r_fb} + {1'b0, i_offset};
   assign w_avail  = r_index - r_fb;

   always_comb begin
      w_idx_n    = r_index;
      w_fb_n     = r_fb;
      w_src_n    = r_src;
      w_dst_n    = r_dst;
      w_left_n   = r_left;
      w_cnt_n    = r_cnt;
      w_err      = 1'b0;
      w_err_code = STS_NONE;
      w_finish   = 1'b0;
      w_go_copy  = 1'b0;
      w_get      = 1'b0;
      w_we       = 1'b0;
      w_waddr    = '0;
      w_wdata    = '0;
      w_fr_push  = 1'b0;
      w_fr_pop   = 1'b0;
      if (r_state == S_COPY) begin
         // dst never exceeds src, so ascending copy cannot clobber unread data
         w_we     = 1'b1;
         w_waddr  = r_dst;
         w_wdata  = r_mem[r_src[DEPTH-1:0]];
         w_src_n  = r_src + AW'(1);
         w_dst_n  = r_dst + AW'(1);
         w_left_n = r_left - AW'(1);
         if (r_left == AW'(1)) begin
            w_finish = 1'b1;
            w_idx_n  = r_fb + r_cnt;
            w_fb_n   = w_fr_top;
            w_fr_pop = 1'b1;
         end
      end else if (w_accept) begin
         w_finish = 1'b1;
         case (i_op)
            OP_NOP: ;
            OP_PUSH: begin
               if (r_index == MAX_IDX) begin
                  w_err = 1'b1; w_err_code = STS_OVERFLOW;
               end else begin
                  w_we = 1'b1; w_waddr = r_index; w_wdata = i_data;
                  w_idx_n = r_index + AW'(1);
               end
            end
            OP_POP: begin
               if (i_count > w_avail) begin
                  w_err = 1'b1; w_err_code = STS_UNDERFLOW;
               end else
                  w_idx_n = r_index - i_count;
            end
            OP_REPLACE: begin
               if (r_index == r_fb) begin
                  w_err = 1'b1; w_err_code = STS_UNDERFLOW;
               end else begin
                  w_we = 1'b1; w_waddr = r_index - AW'(1); w_wdata = i_data;
               end
            end
            OP_ENTER: begin
               if (w_fr_depth == FMAX_D) begin
                  w_err = 1'b1; w_err_code = STS_FRAME_OVERFLOW;
               end else begin
                  w_fr_push = 1'b1;
                  w_fb_n    = r_index;
               end
            end
            OP_LEAVE: begin
               if (w_fr_depth == '0) begin
                  w_err = 1'b1; w_err_code = STS_FRAME_UNDERFLOW;
               end else if (i_count > w_avail) begin
                  w_err = 1'b1; w_err_code = STS_UNDERFLOW;
               end else if (i_count == '0) begin
                  w_idx_n  = r_fb;
                  w_fb_n   = w_fr_top;
                  w_fr_pop = 1'b1;
               end else begin
                  w_finish  = 1'b0;
                  w_go_copy = 1'b1;
                  w_src_n   = r_index - i_count;
                  w_dst_n   = r_fb;
                  w_left_n  = i_count;
                  w_cnt_n   = i_count;
               end
            end
            OP_GET: begin
               if (w_pos >= {1'b0, r_index}) begin
                  w_err = 1'b1; w_err_code = STS_BAD_OFFSET;
               end else
                  w_get = 1'b1;
            end
            OP_SET: begin
               if (w_pos > {1'b0, r_index}) begin
                  w_err = 1'b1; w_err_code = STS_BAD_OFFSET;
               end else if (w_pos == {1'b0, MAX_IDX}) begin
                  w_err = 1'b1; w_err_code = STS_OVERFLOW;
               end else begin
                  w_we = 1'b1; w_waddr = w_pos[AW-1:0]; w_wdata = i_data;
                  if (w_pos == {1'b0, r_index})
                     w_idx_n = r_index + AW'(1);
               end
            end
            default: begin
               w_err = 1'b1; w_err_code = STS_UNKNOWN_OP;
            end
         endcase
      end
   end

   always_comb begin
      if (w_err)
         w_st_n = w_err_code;
      else if (w_idx_n == MAX_IDX)
         w_st_n = STS_FULL;
      else if (w_idx_n == w_fb_n)
         w_st_n = STS_EMPTY;
      else
         w_st_n = STS_NONE;
   end

   // Lanes reflect post-op state; the write landing this cycle is forwarded.
   always_comb begin
      w_lanes = r_out;
      w_lp    = '0;
      if (w_get) begin
         w_lanes[WIDTH-1:0] = r_mem[w_pos[DEPTH-1:0]];
      end else begin
         for (int k = 0; k < OUTS; k++) begin
            w_lp = {1'b0, w_idx_n} - PW'(k + 1);
            if ({1'b0, w_idx_n} < ({1'b0, w_fb_n} + PW'(k + 1)))
               w_lanes[k*WIDTH +: WIDTH] = '0;
            else if (w_we && ({1'b0, w_waddr} == w_lp))
               w_lanes[k*WIDTH +: WIDTH] = w_wdata;
            else
               w_lanes[k*WIDTH +: WIDTH] = r_mem[w_lp[DEPTH-1:0]];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_we)
         r_mem[w_waddr[DEPTH-1:0]] <= w_wdata;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_index  <= '0;
         r_fb     <= '0;
         r_src    <= '0;
         r_dst    <= '0;
         r_left   <= '0;
         r_cnt    <= '0;
         r_out    <= '0;
         r_status <= STS_EMPTY;
         r_done   <= 1'b0;
         r_ready  <= 1'b1;
      end else begin
         r_done <= w_finish;
         r_src  <= w_src_n;
         r_dst  <= w_dst_n;
         r_left <= w_left_n;
         r_cnt  <= w_cnt_n;
         if (w_go_copy) begin
            r_state <= S_COPY;
            r_ready <= 1'b0;
         end else if (w_finish) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_index  <= w_idx_n;
            r_fb     <= w_fb_n;
            r_out    <= w_lanes;
            r_status <= w_st_n;
         end
      end
   end

   assign o_op_ready    = r_ready;
   assign o_index       = r_index;
   assign o_frame_base  = r_fb;
   assign o_frame_depth = w_fr_depth;
   assign o_out         = r_out;
   assign o_status      = r_status;
   assign o_done        = r_done;

endmodule

// File: tb/tb_block_stack.sv
// Self-checking bench for block_stack: table-driven ops scored on done, plus LEAVE/reset/limit sequences.
module tb_block_stack;

   localparam logic [3:0] NOP = 4'd0, PUSH = 4'd1, POP = 4'd2, REPL = 4'd3,
                          ENTER = 4'd4, LEAVE = 4'd5, GET = 4'd6, SET = 4'd7;
   localparam logic [3:0] S_NONE = 4'd0, S_EMPTY = 4'd1, S_FULL = 4'd2, S_UNDER = 4'd3,
                          S_OVER = 4'd4, S_BADOFF = 4'd5, S_FOVER = 4'd6, S_FUNDER = 4'd7,
                          S_UNK = 4'd8;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] data;
      logic [7:0]  count;
      logic [7:0]  offset;
      logic [7:0]  e_idx;
      logic [3:0]  e_st;
      logic [31:0] e_lane0;
      bit          chk_lane;
      logic [4:0]  e_fd;
      bit          chk_fd;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid = 1'b0;
   logic [3:0]  op = '0;
   logic [31:0] data = '0;
   logic [7:0]  count = '0;
   logic [7:0]  offset = '0;
   bit          sel_small = 1'b0;

   logic        m_ready, m_done;
   logic [7:0]  m_index, m_fb;
   logic [4:0]  m_fd;
   logic [95:0] m_out;
   logic [3:0]  m_status;

   logic        s_ready, s_done;
   logic [2:0]  s_index, s_fb;
   logic [1:0]  s_fd;
   logic [7:0]  s_out;
   logic [3:0]  s_status;

   logic        cur_ready, cur_done;
   logic [7:0]  cur_index;
   logic [4:0]  cur_fd;
   logic [31:0] cur_lane0;
   logic [3:0]  cur_status;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t sbq[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   block_stack dut (
      .i_clk(clk), .i_reset(reset), .i_op_valid(op_valid), .o_op_ready(m_ready),
      .i_op(op), .i_data(data), .i_count(count), .i_offset(offset),
      .o_index(m_index), .o_frame_base(m_fb), .o_frame_depth(m_fd),
      .o_out(m_out), .o_status(m_status), .o_done(m_done)
   );

   block_stack #(.WIDTH(8), .DEPTH(2), .FDEPTH(1), .OUTS(1)) dut_s (
      .i_clk(clk), .i_reset(reset), .i_op_valid(op_valid), .o_op_ready(s_ready),
      .i_op(op), .i_data(data[7:0]), .i_count(count[2:0]), .i_offset(offset[2:0]),
      .o_index(s_index), .o_frame_base(s_fb), .o_frame_depth(s_fd),
      .o_out(s_out), .o_status(s_status), .o_done(s_done)
   );

   assign cur_ready  = sel_small ? s_ready : m_ready;
   assign cur_done   = sel_small ? s_done : m_done;
   assign cur_index  = sel_small ? {5'b0, s_index} : m_index;
   assign cur_fd     = sel_small ? {3'b0, s_fd} : m_fd;
   assign cur_lane0  = sel_small ? {24'b0, s_out} : m_out[31:0];
   assign cur_status = sel_small ? s_status : m_status;

   function automatic void check(string nm, logic [95:0] act, logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void fail_now(string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired at %0t", nm, $time);
   endfunction

   function automatic vec_t mk(logic [3:0] o, logic [31:0] d, logic [7:0] c, logic [7:0] f,
                               logic [7:0] ei, logic [3:0] es, bit cl, logic [31:0] el,
                               bit cf, logic [4:0] ef);
      vec_t v;
      v.op = o; v.data = d; v.count = c; v.offset = f; v.e_idx = ei; v.e_st = es;
      v.chk_lane = cl; v.e_lane0 = el; v.chk_fd = cf; v.e_fd = ef;
      return v;
   endfunction

   always @(negedge clk) begin : mon
      vec_t e;
      if (!reset && cur_done) begin
         if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected done=0 at %0t", $time);
         end else begin
            e = sbq.pop_front();
            check("index", cur_index, e.e_idx);
            check("status", cur_status, e.e_st);
            if (e.chk_lane) check("lane0", cur_lane0, e.e_lane0);
            if (e.chk_fd)   check("frame_depth", cur_fd, e.e_fd);
         end
      end
   end

   task automatic send(input vec_t v, input bit expect_done);
      int n = 0;
      while (!cur_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cur_ready) fail_now("ready_wait");
      op_valid = 1'b1;
      op = v.op; data = v.data; count = v.count; offset = v.offset;
      if (expect_done) sbq.push_back(v);
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         fail_now("drain");
         sbq.delete();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      op_valid = 1'b0;
      repeat (2) @(negedge clk);
      sbq.delete();
      reset = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      int n;
      int dones;

      @(negedge clk);
      do_reset();
      check("rst_index", m_index, 0);
      check("rst_fb", m_fb, 0);
      check("rst_fd", m_fd, 0);
      check("rst_out", m_out, 0);
      check("rst_status", m_status, S_EMPTY);
      check("rst_done", m_done, 0);
      check("rst_ready", m_ready, 1);

      // main table: basic ops, frame view, GET/SET, error paths
      tbl.push_back(mk(PUSH,  32'hA, 0, 0, 1, S_NONE,   1, 32'hA, 0, 0));
      tbl.push_back(mk(PUSH,  32'hB, 0, 0, 2, S_NONE,   1, 32'hB, 0, 0));
      tbl.push_back(mk(PUSH,  32'hC, 0, 0, 3, S_NONE,   1, 32'hC, 0, 0));
      foreach (tbl[i]) send(tbl[i], 1'b1);
      drain();
      check("lanes_cba", m_out, {32'hA, 32'hB, 32'hC});
      tbl.delete();
      tbl.push_back(mk(POP,   0, 3, 0, 0, S_EMPTY,  1, 0, 0, 0));
      tbl.push_back(mk(NOP,   0, 0, 0, 0, S_EMPTY,  0, 0, 0, 0));
      tbl.push_back(mk(4'd9,  0, 0, 0, 0, S_UNK,    0, 0, 0, 0));
      tbl.push_back(mk(POP,   0, 1, 0, 0, S_UNDER,  0, 0, 0, 0));
      tbl.push_back(mk(REPL,  5, 0, 0, 0, S_UNDER,  0, 0, 0, 0));
      tbl.push_back(mk(PUSH,  3, 0, 0, 1, S_NONE,   1, 3, 0, 0));
      tbl.push_back(mk(REPL,  4, 0, 0, 1, S_NONE,   1, 4, 0, 0));
      tbl.push_back(mk(POP,   0, 0, 0, 1, S_NONE,   1, 4, 0, 0));
      tbl.push_back(mk(PUSH,  5, 0, 0, 2, S_NONE,   1, 5, 0, 0));
      tbl.push_back(mk(ENTER, 0, 0, 0, 2, S_EMPTY,  1, 0, 1, 1));
      tbl.push_back(mk(GET,   0, 0, 0, 2, S_BADOFF, 0, 0, 0, 0));
      tbl.push_back(mk(PUSH,  5, 0, 0, 3, S_NONE,   1, 5, 0, 0));
      tbl.push_back(mk(GET,   0, 0, 0, 3, S_NONE,   1, 5, 0, 0));
      tbl.push_back(mk(SET,   6, 0, 1, 4, S_NONE,   1, 6, 0, 0));
      tbl.push_back(mk(SET,   9, 0, 3, 4, S_BADOFF, 0, 0, 0, 0));
      tbl.push_back(mk(SET,   7, 0, 0, 4, S_NONE,   1, 6, 0, 0));
      tbl.push_back(mk(GET,   0, 0, 0, 4, S_NONE,   1, 7, 0, 0));
      tbl.push_back(mk(POP,   0, 3, 0, 4, S_UNDER,  0, 0, 0, 0));
      tbl.push_back(mk(LEAVE, 0, 3, 0, 4, S_UNDER,  0, 0, 1, 1));
      tbl.push_back(mk(LEAVE, 0, 0, 0, 2, S_NONE,   1, 5, 1, 0));
      tbl.push_back(mk(LEAVE, 0, 0, 0, 2, S_FUNDER, 0, 0, 1, 0));
      tbl.push_back(mk(POP,   0, 2, 0, 0, S_EMPTY,  0, 0, 0, 0));
      foreach (tbl[i]) send(tbl[i], 1'b1);
      drain();

      // LEAVE with copy: two kept entries, ready low for two cycles
      do_reset();
      send(mk(PUSH,  1, 0, 0, 1, S_NONE,  0, 0, 0, 0), 1'b1);
      send(mk(PUSH,  2, 0, 0, 2, S_NONE,  0, 0, 0, 0), 1'b1);
      send(mk(ENTER, 0, 0, 0, 2, S_EMPTY, 0, 0, 1, 1), 1'b1);
      send(mk(PUSH,  7, 0, 0, 3, S_NONE,  0, 0, 0, 0), 1'b1);
      send(mk(PUSH,  8, 0, 0, 4, S_NONE,  0, 0, 0, 0), 1'b1);
      send(mk(PUSH,  9, 0, 0, 5, S_NONE,  0, 0, 0, 0), 1'b1);
      send(mk(LEAVE, 0, 2, 0, 4, S_NONE,  1, 9, 1, 0), 1'b1);
      lows = 0;
      n = 0;
      while (!m_ready && n < 20) begin
         lows++;
         @(negedge clk);
         n++;
      end
      check("leave_ready_low_cycles", lows, 2);
      drain();
      check("leave_lanes", m_out, {32'd2, 32'd8, 32'd9});
      check("leave_fb", m_fb, 0);
      tbl.delete();
      tbl.push_back(mk(GET, 0, 0, 0, 4, S_NONE, 1, 1, 0, 0));
      tbl.push_back(mk(GET, 0, 0, 1, 4, S_NONE, 1, 2, 0, 0));
      tbl.push_back(mk(GET, 0, 0, 2, 4, S_NONE, 1, 8, 0, 0));
      tbl.push_back(mk(GET, 0, 0, 3, 4, S_NONE, 1, 9, 0, 0));
      foreach (tbl[i]) send(tbl[i], 1'b1);
      drain();

      // reset in the middle of a LEAVE copy
      do_reset();
      send(mk(PUSH,  1, 0, 0, 1, S_NONE,  0, 0, 0, 0), 1'b1);
      send(mk(ENTER, 0, 0, 0, 1, S_EMPTY, 0, 0, 0, 0), 1'b1);
      send(mk(PUSH,  4, 0, 0, 2, S_NONE,  0, 0, 0, 0), 1'b1);
      send(mk(PUSH,  5, 0, 0, 3, S_NONE,  0, 0, 0, 0), 1'b1);
      send(mk(PUSH,  6, 0, 0, 4, S_NONE,  0, 0, 0, 0), 1'b1);
      drain();
      send(mk(LEAVE, 0, 3, 0, 0, S_NONE,  0, 0, 0, 0), 1'b0);
      check("copy_ready_low", m_ready, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_index", m_index, 0);
      check("abort_ready", m_ready, 1);
      check("abort_fd", m_fd, 0);
      dones = 0;
      repeat (5) begin
         if (m_done) dones++;
         @(negedge clk);
      end
      check("abort_no_done", dones, 0);
      send(mk(PUSH, 32'h55, 0, 0, 1, S_NONE, 1, 32'h55, 1, 0), 1'b1);
      drain();

      // small instance: full/overflow/underflow and frame overflow limits
      sel_small = 1'b1;
      do_reset();
      tbl.delete();
      tbl.push_back(mk(PUSH,  8'h11, 0, 0, 1, S_NONE,   1, 8'h11, 0, 0));
      tbl.push_back(mk(PUSH,  8'h22, 0, 0, 2, S_NONE,   1, 8'h22, 0, 0));
      tbl.push_back(mk(PUSH,  8'h33, 0, 0, 3, S_NONE,   1, 8'h33, 0, 0));
      tbl.push_back(mk(PUSH,  8'h44, 0, 0, 4, S_FULL,   1, 8'h44, 0, 0));
      tbl.push_back(mk(PUSH,  8'h55, 0, 0, 4, S_OVER,   0, 0, 0, 0));
      tbl.push_back(mk(POP,   0,     5, 0, 4, S_UNDER,  0, 0, 0, 0));
      tbl.push_back(mk(SET,   8'h66, 0, 4, 4, S_OVER,   0, 0, 0, 0));
      tbl.push_back(mk(GET,   0,     0, 0, 4, S_FULL,   1, 8'h11, 0, 0));
      tbl.push_back(mk(POP,   0,     4, 0, 0, S_EMPTY,  0, 0, 0, 0));
      tbl.push_back(mk(ENTER, 0,     0, 0, 0, S_EMPTY,  0, 0, 1, 1));
      tbl.push_back(mk(ENTER, 0,     0, 0, 0, S_EMPTY,  0, 0, 1, 2));
      tbl.push_back(mk(ENTER, 0,     0, 0, 0, S_FOVER,  0, 0, 1, 2));
      foreach (tbl[i]) send(tbl[i], 1'b1);
      drain();
      sel_small = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
